rv32imf_obi_instr_responder: RTL and testbench

OBI responder that terminates the instruction-fetch bus driven by the core's prefetch path and serves reads from a single-port synchronous SRAM. Grants requests, issues the SRAM read, and returns in-order responses with a fixed, parameterised latency. Out-of-range addresses return an error response. Instantiated in the core testbench and the FPGA top as the instruction memory.

---
 rtl/rv32imf_obi_pkg.sv | 23 ++
 rtl/rv32imf_obi_stall_lfsr.sv | 26 ++
 rtl/rv32imf_obi_instr_responder.sv | 118 +++++++++++
 tb/tb_rv32imf_obi_instr_responder.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32imf_obi_pkg.sv
// Shared types and helpers for the rv32imf OBI instruction responder.
// Covers the response bundle, the per-stage pipeline tag and the address range check.
package rv32imf_obi_pkg;

  localparam int OBI_DATA_W = 32;

  typedef struct packed {
    logic                  rvalid;
    logic                  err;
    logic [OBI_DATA_W-1:0] rdata;
  } obi_resp_t;

  typedef struct packed {
    logic valid;
    logic err;
  } obi_stage_t;

  // A byte offset below the base wraps to a huge value and therefore fails the check.
  function automatic logic addr_in_range(input logic [31:0] off, input int unsigned words);
    return {2'b00, off[31:2]} < words;
  endfunction

endpackage

// File: rtl/rv32imf_obi_stall_lfsr.sv
// Pseudo-random grant throttle, only built when RV32IMF_OBI_STALL_EN is defined.
// A 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) stalls when its two LSBs are zero.
module rv32imf_obi_stall_lfsr
  import rv32imf_obi_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  output logic stall
);

  logic [15:0] lfsr;
  logic        feedback;

  assign feedback = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {lfsr[14:0], feedback};
    end
  end

  assign stall = (lfsr[1:0] == 2'b00);

endmodule

// File: rtl/rv32imf_obi_instr_responder.sv
// OBI instruction-fetch responder backed by a 1-cycle synchronous SRAM, fixed-latency in-order responses.
// Define RV32IMF_OBI_STALL_EN to throttle grants with an LFSR for initiator stress testing.
module rv32imf_obi_instr_responder
  import rv32imf_obi_pkg::*;
#(
  parameter int unsigned LATENCY         = 1,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned MEM_WORDS       = 16384,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         obi_req_i,
  output logic                         obi_gnt_o,
  input  logic [31:0]                  obi_addr_i,
  output logic                         obi_rvalid_o,
  output logic [OBI_DATA_W-1:0]        obi_rdata_o,
  output logic                         obi_err_o,
  output logic                         mem_req_o,
  output logic [$clog2(MEM_WORDS)-1:0] mem_addr_o,
  input  logic [OBI_DATA_W-1:0]        mem_rdata_i
);

  localparam int          AW      = $clog2(MEM_WORDS);
  localparam int          CW      = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  logic [31:0]           off;
  logic                  in_range;
  logic                  stall;
  logic                  resp_fire;
  logic                  gnt;
  logic [CW-1:0]         cnt;
  obi_stage_t            stage_q [LATENCY];
  logic [OBI_DATA_W-1:0] rdata_raw;
  obi_resp_t             resp;

  assign off      = obi_addr_i - BASE_ADDR;
  assign in_range = addr_in_range(off, MEM_WORDS);

`ifdef RV32IMF_OBI_STALL_EN
  rv32imf_obi_stall_lfsr u_stall_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .stall (stall)
  );
`else
  assign stall = 1'b0;
`endif

  assign resp_fire = stage_q[LATENCY-1].valid;

  // A response leaving this cycle frees a slot, so a full responder can still grant.
  assign gnt = rst_n && obi_req_i && !stall && ((cnt < MAX_CNT) || resp_fire);

  assign obi_gnt_o  = gnt;
  assign mem_req_o  = gnt && in_range;
  assign mem_addr_o = mem_req_o ? off[AW+1:2] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= '{valid: gnt, err: !in_range};
      for (int i = 1; i < LATENCY; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      case ({gnt, resp_fire})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // SRAM data is valid one cycle after the read, i.e. alongside stage 0; deeper stages just carry it.
  if (LATENCY == 1) begin : g_lat1
    assign rdata_raw = mem_rdata_i;
  end else begin : g_latn
    logic [OBI_DATA_W-1:0] data_q [1:LATENCY-1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 1; i < LATENCY; i++) begin
          data_q[i] <= '0;
        end
      end else begin
        data_q[1] <= mem_rdata_i;
        for (int i = 2; i < LATENCY; i++) begin
          data_q[i] <= data_q[i-1];
        end
      end
    end

    assign rdata_raw = data_q[LATENCY-1];
  end

  always_comb begin
    resp        = '0;
    resp.rvalid = stage_q[LATENCY-1].valid;
    resp.err    = resp.rvalid && stage_q[LATENCY-1].err;
    resp.rdata  = (resp.rvalid && !resp.err) ? rdata_raw : '0;
  end

  assign obi_rvalid_o = resp.rvalid;
  assign obi_err_o    = resp.err;
  assign obi_rdata_o  = resp.rdata;

endmodule

// File: tb/tb_rv32imf_obi_instr_responder.sv
// Directed and random self-checking bench for rv32imf_obi_instr_responder.
// Three instances: A (LATENCY 1), B (LATENCY 3 / 3 outstanding, scoreboarded), C (LATENCY 3 / 1 outstanding).
module tb_rv32imf_obi_instr_responder;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int          MW   = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int stalls = 0;

  logic        req_a = 1'b0, gnt_a, rvalid_a, err_a, mreq_a;
  logic [31:0] addr_a = '0, rdata_a, mrdata_a = '0;
  logic [5:0]  maddr_a;
  logic        req_b = 1'b0, gnt_b, rvalid_b, err_b, mreq_b;
  logic [31:0] addr_b = '0, rdata_b, mrdata_b = '0;
  logic [5:0]  maddr_b;
  logic        req_c = 1'b0, gnt_c, rvalid_c, err_c, mreq_c;
  logic [31:0] addr_c = '0, rdata_c, mrdata_c = '0;
  logic [5:0]  maddr_c;

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  exp_t e;

  function automatic logic [31:0] mem_word(input logic [31:0] w);
    return (w == 32'd4) ? 32'hDEAD_BEEF : (32'hC0DE_0000 + w);
  endfunction

  function automatic logic in_rng(input logic [31:0] a);
    logic [31:0] o;
    o = a - BASE;
    return (o >> 2) < 32'(MW);
  endfunction

  rv32imf_obi_instr_responder #(.LATENCY(1), .MAX_OUTSTANDING(1), .MEM_WORDS(MW), .BASE_ADDR(BASE)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .obi_req_i(req_a), .obi_gnt_o(gnt_a), .obi_addr_i(addr_a),
    .obi_rvalid_o(rvalid_a), .obi_rdata_o(rdata_a), .obi_err_o(err_a),
    .mem_req_o(mreq_a), .mem_addr_o(maddr_a), .mem_rdata_i(mrdata_a));

  rv32imf_obi_instr_responder #(.LATENCY(3), .MAX_OUTSTANDING(3), .MEM_WORDS(MW), .BASE_ADDR(BASE)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .obi_req_i(req_b), .obi_gnt_o(gnt_b), .obi_addr_i(addr_b),
    .obi_rvalid_o(rvalid_b), .obi_rdata_o(rdata_b), .obi_err_o(err_b),
    .mem_req_o(mreq_b), .mem_addr_o(maddr_b), .mem_rdata_i(mrdata_b));

  rv32imf_obi_instr_responder #(.LATENCY(3), .MAX_OUTSTANDING(1), .MEM_WORDS(MW), .BASE_ADDR(BASE)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .obi_req_i(req_c), .obi_gnt_o(gnt_c), .obi_addr_i(addr_c),
    .obi_rvalid_o(rvalid_c), .obi_rdata_o(rdata_c), .obi_err_o(err_c),
    .mem_req_o(mreq_c), .mem_addr_o(maddr_c), .mem_rdata_i(mrdata_c));

  // Behavioural SRAMs: one-cycle read latency, output holds between reads.
  always @(posedge clk) begin
    if (mreq_a) mrdata_a <= mem_word(32'(maddr_a));
    if (mreq_b) mrdata_b <= mem_word(32'(maddr_b));
    if (mreq_c) mrdata_c <= mem_word(32'(maddr_c));
    cyc <= cyc + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input int sel, input logic r, input logic [31:0] a);
    @(posedge clk);
    #1;
    case (sel)
      0:       begin req_a = r; addr_a = a; end
      1:       begin req_b = r; addr_b = a; end
      default: begin req_c = r; addr_c = a; end
    endcase
    #1;
  endtask

  // Scoreboard for instance B: order, data, error flag, exact latency and SRAM handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      sbq.delete();
    end else begin
      if (rvalid_b) begin
        if (sbq.size() == 0) begin
          checkOutput("b_spurious_rvalid", 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          checkOutput("b_err", 32'(err_b), 32'(e.err));
          checkOutput("b_rdata", rdata_b, e.data);
          checkOutput("b_latency", cyc, e.cyc + 3);
        end
      end else begin
        checkOutput("b_idle_zero", rdata_b | 32'(err_b), 32'd0);
      end
      if (req_b && gnt_b) begin
        checkOutput("b_mem_req", 32'(mreq_b), 32'(in_rng(addr_b)));
        if (in_rng(addr_b)) checkOutput("b_mem_addr", 32'(maddr_b), (addr_b - BASE) >> 2);
        sbq.push_back('{err: !in_rng(addr_b),
                        data: in_rng(addr_b) ? mem_word((addr_b - BASE) >> 2) : 32'h0,
                        cyc: cyc});
      end else begin
        checkOutput("b_memreq_no_gnt", 32'(mreq_b), 32'd0);
      end
`ifdef RV32IMF_OBI_STALL_EN
      if (req_b && !gnt_b && (u_dut_b.cnt < 2'd3 || rvalid_b)) stalls++;
`endif
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL timeout: simulation did not finish, got %0d/%0d", passed, checks);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic        r;
    logic [31:0] a;
    logic        hold;
    int          w;
    int          grants;
    int          n;
    logic [31:0] oor [2];

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_gnt", 32'(gnt_a | gnt_b | gnt_c), 32'd0);
    checkOutput("rst_rvalid", 32'(rvalid_a | rvalid_b | rvalid_c), 32'd0);
    checkOutput("rst_rdata", rdata_a | rdata_b | rdata_c, 32'd0);
    checkOutput("rst_err", 32'(err_a | err_b | err_c), 32'd0);
    checkOutput("rst_mem_req", 32'(mreq_a | mreq_b | mreq_c), 32'd0);
    checkOutput("rst_mem_addr", 32'(maddr_a | maddr_b | maddr_c), 32'd0);
    checkOutput("rst_cnt", 32'(u_dut_b.cnt), 32'd0);
    rst_n = 1'b1;

`ifndef RV32IMF_OBI_STALL_EN
    // Instance A: single read of word 4 with LATENCY 1.
    applyStimulus(0, 1'b1, BASE + 32'h10);
    checkOutput("a_gnt", 32'(gnt_a), 32'd1);
    checkOutput("a_mem_req", 32'(mreq_a), 32'd1);
    checkOutput("a_mem_addr", 32'(maddr_a), 32'd4);
    applyStimulus(0, 1'b0, 32'h0);
    checkOutput("a_rvalid", 32'(rvalid_a), 32'd1);
    checkOutput("a_rdata", rdata_a, 32'hDEAD_BEEF);
    checkOutput("a_err", 32'(err_a), 32'd0);
    applyStimulus(0, 1'b0, 32'h0);
    checkOutput("a_rvalid_low", 32'(rvalid_a), 32'd0);
    checkOutput("a_rdata_gated", rdata_a, 32'd0);

    // Instance A: one past the top and one below the base.
    oor[0] = BASE + 32'(4 * MW);
    oor[1] = BASE - 32'd4;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 1'b1, oor[i]);
      checkOutput("a_oor_gnt", 32'(gnt_a), 32'd1);
      checkOutput("a_oor_mem_req", 32'(mreq_a), 32'd0);
      applyStimulus(0, 1'b0, 32'h0);
      checkOutput("a_oor_rvalid", 32'(rvalid_a), 32'd1);
      checkOutput("a_oor_err", 32'(err_a), 32'd1);
      checkOutput("a_oor_rdata", rdata_a, 32'd0);
    end

    // Instance B: back-to-back reads of words 0..7 must be granted every cycle.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 1'b1, BASE + 32'(4 * i));
      checkOutput("b_b2b_gnt", 32'(gnt_b), 32'd1);
    end
    applyStimulus(1, 1'b0, 32'h0);
    repeat (12) @(posedge clk);
    #2;
    checkOutput("b_b2b_drain", 32'(sbq.size()), 32'd0);

    // Instance C: one outstanding, so grants land every third cycle.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(2, 1'b1, BASE + 32'h8);
      checkOutput("c_gnt", 32'(gnt_c), 32'((i % 3) == 0));
      checkOutput("c_rvalid", 32'(rvalid_c), 32'((i > 0) && ((i % 3) == 0)));
      if ((i > 0) && ((i % 3) == 0)) checkOutput("c_rdata", rdata_c, mem_word(32'd2));
      checkOutput("c_cnt_max", 32'(u_dut_c.cnt <= 1'b1), 32'd1);
    end
    applyStimulus(2, 1'b0, 32'h0);

    // Instance B: reset with two responses in flight, then a normal read.
    applyStimulus(1, 1'b1, BASE + 32'd4);
    checkOutput("b_pre_rst_gnt0", 32'(gnt_b), 32'd1);
    applyStimulus(1, 1'b1, BASE + 32'd8);
    checkOutput("b_pre_rst_gnt1", 32'(gnt_b), 32'd1);
    @(posedge clk);
    #1;
    req_b = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("b_rst_rvalid", 32'(rvalid_b), 32'd0);
    checkOutput("b_rst_outs", rdata_b | 32'(err_b) | 32'(gnt_b) | 32'(mreq_b), 32'd0);
    checkOutput("b_rst_cnt", 32'(u_dut_b.cnt), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 1'b0, 32'h0);
      checkOutput("b_post_rst_rvalid", 32'(rvalid_b), 32'd0);
    end
    applyStimulus(1, 1'b1, BASE + 32'd24);
    checkOutput("b_post_rst_gnt", 32'(gnt_b), 32'd1);
    applyStimulus(1, 1'b0, 32'h0);
    repeat (6) @(posedge clk);
    #2;
    checkOutput("b_post_rst_drain", 32'(sbq.size()), 32'd0);
`endif

    // Instance B: random traffic; req/addr are held stable until granted.
    hold   = 1'b0;
    grants = 0;
    n      = 0;
    r      = 1'b0;
    a      = '0;
    while (grants < 1000 && n < 5000) begin
      if (!hold) begin
        r = ($urandom_range(0, 3) != 0);
        w = int'($urandom_range(0, 71));
        if (w < 64)      a = BASE + 32'(4 * w) + 32'($urandom_range(0, 3));
        else if (w < 68) a = BASE + 32'(4 * w);
        else             a = BASE - 32'(4 * (w - 67));
      end
      applyStimulus(1, r, a);
      if (r && gnt_b) grants++;
      hold = r && !gnt_b;
      n++;
    end
    checkOutput("rand_grants", 32'(grants), 32'd1000);
    applyStimulus(1, 1'b0, 32'h0);
    repeat (6) @(posedge clk);
    #2;
    checkOutput("rand_drain", 32'(sbq.size()), 32'd0);
`ifdef RV32IMF_OBI_STALL_EN
    checkOutput("stall_seen", 32'(stalls > 0), 32'd1);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
